// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, GF(2^8) arithmetic, S-boxes, rcon and word helpers
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        READY  = 2'd2,
        BUSY   = 2'd3
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         bypass_mix,
    output logic [127:0] state_out
);

    logic [127:0] sb;
    logic [127:0] mx;

    always_comb begin
        sb = '0;
        mx = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                // row r rotates right by r, so output column c reads input column c-r
                sb[127-8*(r+4*c) -: 8] = inv_sbox(state_in[127-8*(r+4*((c+4-r)%4)) -: 8])
                                       ^ round_key[127-8*(r+4*c) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                mx[127-8*(r+4*c) -: 8] = gf_mul(8'h0e, sb[127-8*(r+4*c) -: 8])
                                       ^ gf_mul(8'h0b, sb[127-8*(((r+1)%4)+4*c) -: 8])
                                       ^ gf_mul(8'h0d, sb[127-8*(((r+2)%4)+4*c) -: 8])
                                       ^ gf_mul(8'h09, sb[127-8*(((r+3)%4)+4*c) -: 8]);
            end
        end
        state_out = bypass_mix ? sb : mx;
    end

endmodule

// File: rtl/aes_decrypt_engine.sv
// rtl/aes_decrypt_engine.sv - iterative AES-128 decrypt engine, one round per clock, inverse key schedule on the fly
// Build option AES_DEC_HALT_ZEROIZE_EN: halt also clears key, state and out registers.
module aes_decrypt_engine
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         set_key,
    input  logic [127:0] key,
    input  logic         start,
    input  logic [127:0] state,
    input  logic         halt,
    output logic [127:0] out,
    output logic         out_valid,
    output logic         ready
);

    fsm_t         fsm_q, fsm_d;
    logic [127:0] k0_q, k0_d;
    logic [127:0] k10_q, k10_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] st_q, st_d;
    logic [127:0] out_q, out_d;
    logic [3:0]   rcnt_q, rcnt_d;
    logic         out_valid_q, out_valid_d;

    logic         final_round;
    logic [127:0] round_out;

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // undoes key_fwd: recover w3..w1 first, then w0 from the recovered w3
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    assign final_round = (rcnt_q == 4'd0);

    aes_inv_round u_round (
        .state_in  (st_q),
        .round_key (final_round ? k0_q : rk_q),
        .bypass_mix(final_round),
        .state_out (round_out)
    );

    always_comb begin
        fsm_d       = fsm_q;
        k0_d        = k0_q;
        k10_d       = k10_q;
        rk_d        = rk_q;
        st_d        = st_q;
        out_d       = out_q;
        rcnt_d      = rcnt_q;
        out_valid_d = 1'b0;
        if (halt) begin
            fsm_d = IDLE;
`ifdef AES_DEC_HALT_ZEROIZE_EN
            k0_d  = '0;
            k10_d = '0;
            rk_d  = '0;
            st_d  = '0;
            out_d = '0;
`endif
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (set_key) begin
                        k0_d   = key;
                        rk_d   = key;
                        rcnt_d = 4'd0;
                        fsm_d  = KEYEXP;
                    end
                end
                KEYEXP: begin
                    rk_d   = key_fwd(rk_q, rcon(rcnt_q + 4'd1));
                    rcnt_d = rcnt_q + 4'd1;
                    if (rcnt_q == 4'(NR - 1)) begin
                        k10_d = key_fwd(rk_q, rcon(rcnt_q + 4'd1));
                        fsm_d = READY;
                    end
                end
                READY: begin
                    if (set_key) begin
                        k0_d   = key;
                        rk_d   = key;
                        rcnt_d = 4'd0;
                        fsm_d  = KEYEXP;
                    end else if (start) begin
                        st_d   = state ^ k10_q;
                        rk_d   = key_inv(k10_q, rcon(4'(NR)));
                        rcnt_d = 4'(NR - 1);
                        fsm_d  = BUSY;
                    end
                end
                BUSY: begin
                    if (!final_round) begin
                        st_d   = round_out;
                        rk_d   = key_inv(rk_q, rcon(rcnt_q));
                        rcnt_d = rcnt_q - 4'd1;
                    end else begin
                        out_d       = round_out;
                        out_valid_d = 1'b1;
                        fsm_d       = READY;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            k0_q        <= '0;
            k10_q       <= '0;
            rk_q        <= '0;
            st_q        <= '0;
            out_q       <= '0;
            rcnt_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            k0_q        <= k0_d;
            k10_q       <= k10_d;
            rk_q        <= rk_d;
            st_q        <= st_d;
            out_q       <= out_d;
            rcnt_q      <= rcnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign ready     = (fsm_q == READY);

endmodule

// File: tb/tb_aes_decrypt_engine.sv
// tb/tb_aes_decrypt_engine.sv - scoreboard bench for aes_decrypt_engine using a forward AES-128 encrypt model
module tb_aes_decrypt_engine;

    logic         clk;
    logic         rst_n;
    logic         set_key;
    logic [127:0] key_in;
    logic         start;
    logic [127:0] state_in;
    logic         halt;
    logic [127:0] out;
    logic         out_valid;
    logic         ready;

    int checks;
    int errors;

    logic [127:0] exp_q[$];
    logic [7:0]   sbox_t [256];
    logic [7:0]   g_p, g_q, g_x;
    logic [127:0] cur_key;
    logic [127:0] last_pt;
    logic         prev_valid;

    aes_decrypt_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_key  (set_key),
        .key      (key_in),
        .start    (start),
        .state    (state_in),
        .halt     (halt),
        .out      (out),
        .out_valid(out_valid),
        .ready    (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] tb_sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Reference: full key schedule, then forward cipher; decrypting the result must give pt back
    function automatic logic [127:0] aes_encrypt(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = tb_sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = mul2(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int n = 0; n < 16; n++) t[n] = sbox_t[s[(n%4) + 4*(((n/4) + (n%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (rnd < 10)
                        s[4*c+r] = mul2(t[4*c+r]) ^ mul2(t[4*c+(r+1)%4]) ^ t[4*c+(r+1)%4]
                                 ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
                    else
                        s[4*c+r] = t[4*c+r];
                    s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
                end
            end
        end
        res = '0;
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        set_key = 1'b1;
        key_in  = k;
        cur_key = k;
        step();
        set_key = 1'b0;
        repeat (9) step();
        chk("ready_before_11_edges", ready, 0);
        step();
        chk("ready_at_11_edges", ready, 1);
    endtask

    task automatic decrypt_one(input logic [127:0] ct, input logic [127:0] pt);
        exp_q.push_back(pt);
        last_pt  = pt;
        start    = 1'b1;
        state_in = ct;
        step();
        start = 1'b0;
        repeat (9) begin
            step();
            chk("busy_ready_low", ready, 0);
            chk("busy_no_valid", out_valid, 0);
        end
        step();
        chk("valid_at_e10", out_valid, 1);
        chk("ready_at_e10", ready, 1);
    endtask

    task automatic back_to_back(input logic [127:0] pt1, input logic [127:0] pt2);
        exp_q.push_back(pt1);
        exp_q.push_back(pt2);
        last_pt  = pt2;
        start    = 1'b1;
        state_in = aes_encrypt(cur_key, pt1);
        step();
        state_in = aes_encrypt(cur_key, pt2);
        repeat (10) step();
        chk("b2b_first_valid", out_valid, 1);
        step();
        start = 1'b0;
        chk("b2b_valid_single", out_valid, 0);
        chk("b2b_second_busy", ready, 0);
        repeat (9) step();
        chk("b2b_no_early_valid", out_valid, 0);
        step();
        chk("b2b_second_valid", out_valid, 1);
    endtask

    // Monitor: every out_valid pulse must match the oldest outstanding expectation
    initial begin
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                checks++;
                if (prev_valid) begin
                    errors++;
                    $display("FAIL out_valid_pulse: got two consecutive cycles high expected single cycle");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got out=%h expected no out_valid", out);
                end else begin
                    logic [127:0] e;
                    e = exp_q.pop_front();
                    if (out !== e) begin
                        errors++;
                        $display("FAIL result_data: got %h expected %h", out, e);
                    end
                end
            end
            prev_valid = (out_valid === 1'b1);
        end
    end

    initial begin
        logic [127:0] k2, pt, ct;
        checks  = 0;
        errors  = 0;
        last_pt = '0;
        cur_key = '0;

        g_p = 8'h01;
        g_q = 8'h01;
        do begin
            g_p = g_p ^ {g_p[6:0], 1'b0} ^ (g_p[7] ? 8'h1b : 8'h00);
            g_q = g_q ^ {g_q[6:0], 1'b0};
            g_q = g_q ^ {g_q[5:0], 2'b0};
            g_q = g_q ^ {g_q[3:0], 4'b0};
            if (g_q[7]) g_q = g_q ^ 8'h09;
            g_x = g_q ^ {g_q[6:0], g_q[7]} ^ {g_q[5:0], g_q[7:6]} ^ {g_q[4:0], g_q[7:5]} ^ {g_q[3:0], g_q[7:4]};
            sbox_t[g_p] = g_x ^ 8'h63;
        end while (g_p != 8'h01);
        sbox_t[0] = 8'h63;

        rst_n    = 1'b0;
        set_key  = 1'b0;
        start    = 1'b0;
        halt     = 1'b0;
        key_in   = '0;
        state_in = '0;
        repeat (2) step();
        chk("reset_out", out, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_ready", ready, 0);
        rst_n = 1'b1;
        step();

        load_key(128'h000102030405060708090a0b0c0d0e0f);
        decrypt_one(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);
        load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        decrypt_one(128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734);

        for (int i = 0; i < 6; i++) begin
            load_key(rand128());
            back_to_back(rand128(), rand128());
            pt = rand128();
            decrypt_one(aes_encrypt(cur_key, pt), pt);
        end

        // start at E+4 and set_key at E+5 land while busy and must be dropped
        pt = rand128();
        exp_q.push_back(pt);
        last_pt  = pt;
        start    = 1'b1;
        state_in = aes_encrypt(cur_key, pt);
        step();
        start = 1'b0;
        repeat (3) step();
        start    = 1'b1;
        state_in = rand128();
        step();
        start   = 1'b0;
        set_key = 1'b1;
        key_in  = rand128();
        step();
        set_key = 1'b0;
        repeat (5) step();
        chk("ignore_valid_at_e10", out_valid, 1);
        step();
        chk("ignore_not_rekeying", ready, 1);
        pt = rand128();
        decrypt_one(aes_encrypt(cur_key, pt), pt);

        // halt mid-block
        start    = 1'b1;
        state_in = rand128();
        step();
        start = 1'b0;
        repeat (4) step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("halt_ready", ready, 0);
        chk("halt_out_valid", out_valid, 0);
`ifdef AES_DEC_HALT_ZEROIZE_EN
        chk("halt_out_zeroized", out, 0);
`else
        chk("halt_out_kept", out, last_pt);
`endif
        start    = 1'b1;
        state_in = rand128();
        step();
        start = 1'b0;
        repeat (12) step();
        chk("idle_start_ignored", ready, 0);

        // asynchronous reset mid-block
        load_key(rand128());
        start    = 1'b1;
        state_in = rand128();
        step();
        start = 1'b0;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", out, 0);
        chk("async_reset_valid", out_valid, 0);
        chk("async_reset_ready", ready, 0);
        #3;
        rst_n = 1'b1;
        step();
        start    = 1'b1;
        state_in = rand128();
        step();
        start = 1'b0;
        repeat (14) step();
        chk("post_reset_no_key", ready, 0);

        k2 = 128'h000102030405060708090a0b0c0d0e0f;
        load_key(k2);
        ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        decrypt_one(ct, 128'h00112233445566778899aabbccddeeff);

        repeat (3) step();
        chk("scoreboard_drained", 128'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
